// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t            : converter FSM states
//   BCD_* constants    : digit width, adjust threshold/value, largest legal digit
//   bin_w_for_digits() : minimum binary width able to hold 10^digits - 1
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam int unsigned BCD_DIGIT_W    = 4;
   localparam int unsigned BCD_ADJ_THRESH = 8;
   localparam int unsigned BCD_ADJ_VAL    = 3;
   localparam int unsigned BCD_MAX_DIGIT  = 9;

   typedef logic [BCD_DIGIT_W-1:0] digit_t;

   // Smallest w with 2^w >= 10^digits.
   function automatic int unsigned bin_w_for_digits(input int unsigned digits);
      longint unsigned pow10;
      int unsigned     w;
      pow10 = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         pow10 = pow10 * 10;
      end
      w = 0;
      while ((longint'(1) << w) < pow10) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Handshake/data bundle of the BCD-to-binary converter.
//   iSTART : conversion request (master -> slave)
//   iBCD   : packed BCD operand, digit 0 in the low nibble (master -> slave)
//   oBUSY  : conversion in progress (slave -> master)
//   oDONE  : one-cycle result-valid pulse (slave -> master)
//   oERR   : operand had a nibble > 9 (slave -> master)
//   oBIN   : binary result (slave -> master)
interface bcd2bin_seq_if
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) ();

   logic                          iSTART;
   logic [DIGITS*BCD_DIGIT_W-1:0] iBCD;
   logic                          oBUSY;
   logic                          oDONE;
   logic                          oERR;
   logic [BIN_W-1:0]              oBIN;

   modport master (
      output iSTART, iBCD,
      input  oBUSY, oDONE, oERR, oBIN
   );

   modport slave (
      input  iSTART, iBCD,
      output oBUSY, oDONE, oERR, oBIN
   );

endinterface

// File: rtl/bcd_digit_sub3.sv
// One BCD digit correction cell for the reverse shift/adjust algorithm:
// a digit of 8 or more has 3 subtracted (4-bit arithmetic, no borrow out).
//   digit_in  : shifted BCD digit
//   digit_out : corrected digit
module bcd_digit_sub3
   import bcd_pkg::*;
(
   input  digit_t digit_in,
   output digit_t digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= digit_t'(BCD_ADJ_THRESH)) begin
         digit_out = digit_in - digit_t'(BCD_ADJ_VAL);
      end
   end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Each CONV cycle shifts {bcd, bin} right by one and then subtracts 3 from
// every BCD digit that is 8 or more; after BIN_W cycles bin holds the value.
//   iCLK : clock, rising edge
//   iRST : synchronous active-high reset
//   bus  : slave side of bcd2bin_seq_if (iSTART/iBCD in, oBUSY/oDONE/oERR/oBIN out)
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input logic          iCLK,
   input logic          iRST,
   bcd2bin_seq_if.slave bus
);

   localparam int unsigned BCD_W = DIGITS * BCD_DIGIT_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   state_t           state;
   logic [BCD_W-1:0] bcd_q;
   logic [BCD_W-1:0] bcd_shift;
   logic [BCD_W-1:0] bcd_adj;
   logic [BIN_W-1:0] bin_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             bad_digit;

   assign bcd_shift = bcd_q >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
         .digit_in  (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bus.iBCD[i*BCD_DIGIT_W +: BCD_DIGIT_W] > digit_t'(BCD_MAX_DIGIT)) begin
            bad_digit = 1'b1;
         end
      end
   end

   // oDONE/oBIN/oERR are registered while leaving DONE, so the pulse lands
   // BIN_W+1 edges after a valid accept and 1 edge after an invalid one.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         bus.oBUSY <= 1'b0;
         bus.oDONE <= 1'b0;
         bus.oERR  <= 1'b0;
         bus.oBIN  <= '0;
      end else begin
         bus.oDONE <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iSTART) begin
                  bcd_q <= bus.iBCD;
                  bin_q <= '0;
                  cnt_q <= '0;
                  err_q <= bad_digit;
                  if (bad_digit) begin
                     state <= DONE;
                  end else begin
                     state     <= CONV;
                     bus.oBUSY <= 1'b1;
                  end
               end
            end
            CONV: begin
               bcd_q <= bcd_adj;
               bin_q <= {bcd_q[0], bin_q[BIN_W-1:1]};
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BIN_W - 1)) begin
                  state     <= DONE;
                  bus.oBUSY <= 1'b0;
               end
            end
            DONE: begin
               bus.oDONE <= 1'b1;
               bus.oBIN  <= err_q ? '0 : bin_q;
               bus.oERR  <= err_q;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               bus.oBUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: a reference process predicts each
// accepted job (value, error flag, oDONE edge) into a scoreboard queue and a
// monitor compares every oDONE pulse against the queue head.
module tb_bcd2bin_seq;
   import bcd_pkg::*;

   localparam int unsigned DIGITS = 3;
   localparam int unsigned BIN_W  = bin_w_for_digits(DIGITS);
   localparam int unsigned BCD_W  = 4 * DIGITS;

   typedef struct {
      int unsigned bin;
      bit          err;
      int unsigned done_edge;
   } exp_t;

   logic        clk;
   logic        rst;
   int unsigned cyc;
   int unsigned next_free;
   int unsigned busy_cnt;
   int unsigned errs;
   int unsigned checks;
   exp_t        sb[$];

   bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
      logic [BCD_W-1:0] b;
      int unsigned      r;
      b = '0;
      r = v;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic exp_t model(input logic [BCD_W-1:0] b, input int unsigned edge_idx);
      exp_t        e;
      int unsigned pow;
      int unsigned d;
      e.bin = 0;
      e.err = 1'b0;
      pow   = 1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) e.err = 1'b1;
         e.bin += d * pow;
         pow   *= 10;
      end
      if (e.err) e.bin = 0;
      e.done_edge = edge_idx + (e.err ? 1 : BIN_W + 1);
      return e;
   endfunction

   // Reference: decides which edges accept a job and what it must produce.
   always @(posedge clk) begin
      exp_t e;
      cyc <= cyc + 1;
      if (rst) begin
         sb.delete();
         next_free <= cyc + 1;
      end else if (bus.iSTART === 1'b1 && cyc >= next_free) begin
         e = model(bus.iBCD, cyc);
         sb.push_back(e);
         next_free <= cyc + (e.err ? 2 : BIN_W + 2);
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (bus.oBUSY === 1'b1) busy_cnt++;
         if (bus.oDONE === 1'b1) begin
            chk("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("oBIN", 32'(bus.oBIN), e.bin);
               chk("oERR", 32'(bus.oERR), 32'(e.err));
               chk("done_edge", cyc - 1, e.done_edge);
               chk("busy_cycles", busy_cnt, e.err ? 0 : BIN_W);
               if (!e.err) chk("bcd_zero", 32'(dut.bcd_q), 0);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_drain(input int unsigned budget);
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic convert(input logic [BCD_W-1:0] b);
      @(posedge clk);
      #1;
      bus.iSTART = 1'b1;
      bus.iBCD   = b;
      @(posedge clk);
      #1;
      bus.iSTART = 1'b0;
      bus.iBCD   = BCD_W'($urandom);
      wait_drain(40);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      errs       = 0;
      checks     = 0;
      busy_cnt   = 0;
      cyc        = 0;
      next_free  = 0;
      rst        = 1'b1;
      bus.iSTART = 1'b0;
      bus.iBCD   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(bus.oBUSY), 0);
      chk("rst_done", 32'(bus.oDONE), 0);
      chk("rst_err",  32'(bus.oERR), 0);
      chk("rst_bin",  32'(bus.oBIN), 0);

      // Directed values, including an invalid operand followed by a valid one.
      convert(12'h999);
      convert(12'h000);
      convert(12'h255);
      convert(12'h100);
      convert(12'h1A0);
      convert(12'h042);

      // iSTART held high with the operand changing every cycle.
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         bus.iSTART = 1'b1;
         bus.iBCD   = (i % 5 == 4) ? BCD_W'($urandom) : to_bcd($urandom_range(0, 999));
      end
      @(posedge clk);
      #1;
      bus.iSTART = 1'b0;
      wait_drain(40);

      // Reset in the middle of a conversion: no oDONE, result cleared.
      @(posedge clk);
      #1;
      bus.iSTART = 1'b1;
      bus.iBCD   = 12'h777;
      @(posedge clk);
      #1;
      bus.iSTART = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.oBUSY), 0);
      chk("abort_done", 32'(bus.oDONE), 0);
      chk("abort_bin",  32'(bus.oBIN), 0);
      repeat (15) @(negedge clk);
      convert(12'h321);

      // All valid codes.
      for (int unsigned v = 0; v < 1000; v++) begin
         convert(to_bcd(v));
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
